// File: rtl/multicycle_alu.sv
// multicycle_alu -- execute-stage ALU with a serial shifter.
//
// Logic, arithmetic, compare and pass ops finish in one cycle. SLL/SRL/SRA
// shift one bit per cycle, so a shift by N keeps in_ready low for N cycles.
// A valid/ready handshake lets the hazard unit stall upstream meanwhile.
//
// Optional build macro: MULTICYCLE_ALU_BARREL_SHIFT_EN
//   defined   -> shifts use a combinational barrel shifter, every op takes
//                one cycle, SHIFT is never entered, in_ready = !reset.
//   undefined -> serial 1-bit-per-cycle shifter (default).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   Operation/SrcA/SrcB valid this cycle
//   in_ready   out  block can accept an op this cycle
//   Operation  in   4-bit op select from the ALU controller
//   SrcA       in   operand A
//   SrcB       in   operand B; SrcB[SHAMT_W-1:0] is the shift amount
//   out_valid  out  one-cycle pulse per accepted op
//   ALUResult  out  registered result, held until the next completion
//   Zero       out  registered (ALUResult == 0)
module multicycle_alu #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero
);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    localparam bit SERIAL = 1'b0;
`else
    localparam bit SERIAL = 1'b1;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [1:0]          r_shop;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;

    logic                w_accept;
    logic                w_is_shift;
    logic [SHAMT_W-1:0]  w_shamt;
    logic                w_start_shift;
    logic                w_done;
    logic [DATA_W-1:0]   w_result_nxt;
    logic [DATA_W-1:0]   w_acc_step;

    // Single-cycle result. In the serial build a shift only reaches this
    // path with shamt == 0, where the result is SrcA unchanged.
    function automatic logic [DATA_W-1:0] op_result(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [DATA_W-1:0]        res;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
        logic [SHAMT_W-1:0]       sh;
        sh = b[SHAMT_W-1:0];
`endif
        sa  = a;
        sb  = b;
        res = '0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0011: res = a ^ b;
            4'b0110: res = a - b;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
            4'b0100: res = a << sh;
            4'b0101: res = a >> sh;
            4'b0111: res = sa >>> sh;
`else
            4'b0100: res = a;
            4'b0101: res = a;
            4'b0111: res = a;
`endif
            4'b1000: res = {{(DATA_W-1){1'b0}}, (a == b)};
            4'b1001: res = {{(DATA_W-1){1'b0}}, (a != b)};
            4'b1010: res = {{(DATA_W-1){1'b0}}, (sa < sb)};
            4'b1011: res = {{(DATA_W-1){1'b0}}, (sa >= sb)};
            4'b1100: res = {{(DATA_W-1){1'b0}}, (a < b)};
            4'b1101: res = {{(DATA_W-1){1'b0}}, (a >= b)};
            4'b1110: res = b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // One serial shift step; shop is Operation[1:0] of the latched shift
    // (00 SLL, 01 SRL, 11 SRA).
    function automatic logic [DATA_W-1:0] shift_step(
        input logic [DATA_W-1:0] acc,
        input logic [1:0]        shop
    );
        logic [DATA_W-1:0] res;
        case (shop)
            2'b00:   res = {acc[DATA_W-2:0], 1'b0};
            2'b01:   res = {1'b0, acc[DATA_W-1:1]};
            default: res = {acc[DATA_W-1], acc[DATA_W-1:1]};
        endcase
        return res;
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_shamt    = SrcB[SHAMT_W-1:0];
    assign w_is_shift = (Operation == 4'b0100) || (Operation == 4'b0101) ||
                        (Operation == 4'b0111);
    assign w_acc_step = shift_step(r_acc, r_shop);

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    assign in_ready = !reset;
`else
    assign in_ready = (r_state == S_IDLE);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_start_shift = 1'b0;
        w_done        = 1'b0;
        w_result_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (SERIAL && w_is_shift && (w_shamt != '0)) begin
                        w_state_nxt   = S_SHIFT;
                        w_start_shift = 1'b1;
                    end else begin
                        w_done       = 1'b1;
                        w_result_nxt = op_result(Operation, SrcA, SrcB);
                    end
                end
            end
            S_SHIFT: begin
                // cnt==1 means this step is the last bit of the shift.
                if (r_cnt == SHAMT_W'(1)) begin
                    w_state_nxt  = S_IDLE;
                    w_done       = 1'b1;
                    w_result_nxt = w_acc_step;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control and visible result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                r_result <= w_result_nxt;
                r_zero   <= (w_result_nxt == '0);
            end
            if (w_start_shift) begin
                r_cnt <= w_shamt;
            end else if (r_state == S_SHIFT) begin
                r_cnt <= r_cnt - SHAMT_W'(1);
            end
        end
    end

    // Shift datapath; its contents are don't-care outside SHIFT.
    always_ff @(posedge clk) begin
        if (w_start_shift) begin
            r_acc  <= SrcA;
            r_shop <= Operation[1:0];
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_acc_step;
        end
    end

    assign out_valid = r_out_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    localparam bit SERIAL = 1'b0;
`else
    localparam bit SERIAL = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic [31:0] ALUResult;
    logic        Zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    multicycle_alu #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: results straight from the operation definitions.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned s;
        logic [31:0] ones;
        s    = b % 32;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd6:  return a - b;
            4'd4:  return a << s;
            4'd5:  return a >> s;
            4'd7:  return (a >> s) | ((a >= 32'h8000_0000) ? ~(ones >> s) : 32'd0);
            4'd8:  return (a == b) ? 32'd1 : 32'd0;
            4'd9:  return (a != b) ? 32'd1 : 32'd0;
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return (a < b) ? 32'd1 : 32'd0;
            4'd13: return (a >= b) ? 32'd1 : 32'd0;
            4'd14: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Clock edges between the accept edge and the edge that raises out_valid.
    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (SERIAL && (op == 4'd4 || op == 4'd5 || op == 4'd7)) return int'(b % 32);
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge. Presents one op, waits for accept, then waits for
    // out_valid and reports result, latency and the in_ready-low count.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat,
                          output int low_cnt, output bit ok);
        int guard;
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        @(negedge clk);
        lat = 0; low_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low_cnt++;
            @(negedge clk);
            lat++;
        end
        ok  = out_valid;
        res = ALUResult;
        z   = Zero;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vtab[$];

    task automatic add_vec(input string n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input logic z,
                           input int lat);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.res = r; v.z = z;
        v.lat = SERIAL ? lat : 0;
        vtab.push_back(v);
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat, low, ovcnt;
        bit          ok;
        logic [3:0]  bb_op[4];
        logic [31:0] bb_a[4], bb_b[4];
        int          acc_cyc[4];
        int          out_cyc[$];
        logic [31:0] out_res[$];

        reset = 1'b1; in_valid = 1'b0; Operation = 4'd0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset ALUResult", ALUResult, 32'd0);
        check("reset Zero", 32'(Zero), 32'd1);
        check("reset in_ready", 32'(in_ready), 32'd1);

        add_vec("ADD ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1'b0, 0);
        add_vec("SUB zero", 4'b0110, 32'd5,         32'd5,        32'h0,         1'b1, 0);
        add_vec("SRA 31",   4'b0111, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1'b0, 31);
        add_vec("SRL 31",   4'b0101, 32'h8000_0000, 32'd31,       32'h1,         1'b0, 31);
        add_vec("SLL sh0",  4'b0100, 32'h1,         32'h20,       32'h1,         1'b0, 0);
        add_vec("SLL 4",    4'b0100, 32'h1,         32'd4,        32'h10,        1'b0, 4);
        add_vec("LT",       4'b1010, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 0);
        add_vec("LTU",      4'b1100, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1, 0);
        add_vec("GE",       4'b1011, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1, 0);
        add_vec("GEU",      4'b1101, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 0);
        add_vec("NE",       4'b1001, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 0);
        add_vec("EQ",       4'b1000, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1, 0);
        add_vec("OP1111",   4'b1111, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1, 0);
        add_vec("PASSB",    4'b1110, 32'hDEAD_0000, 32'h1234,     32'h1234,      1'b0, 0);
        add_vec("AND",      4'b0000, 32'hF0F0_FFFF, 32'h0FF0_00F0, 32'h00F0_00F0, 1'b0, 0);
        add_vec("XOR",      4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 0);
        add_vec("SRA pos",  4'b0111, 32'h4000_0000, 32'd2,        32'h1000_0000, 1'b0, 2);
        add_vec("SRA 1",    4'b0111, 32'h8000_0000, 32'd1,        32'hC000_0000, 1'b0, 1);

        foreach (vtab[i]) begin
            run_op(vtab[i].op, vtab[i].a, vtab[i].b, res, z, lat, low, ok);
            check({vtab[i].name, " done"}, 32'(ok), 32'd1);
            check({vtab[i].name, " result"}, res, vtab[i].res);
            check({vtab[i].name, " zero"}, 32'(z), 32'(vtab[i].z));
            check({vtab[i].name, " latency"}, lat, vtab[i].lat);
            check({vtab[i].name, " ready low"}, low, vtab[i].lat);
            check({vtab[i].name, " ready at done"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            check({vtab[i].name, " single pulse"}, 32'(out_valid), 32'd0);
        end

        // Back-to-back with in_valid held: ADD, XOR, SLL by 3, AND.
        bb_op[0] = 4'b0010; bb_a[0] = 32'd100;        bb_b[0] = 32'd23;
        bb_op[1] = 4'b0011; bb_a[1] = 32'hFF00_FF00;  bb_b[1] = 32'h0FF0_0FF0;
        bb_op[2] = 4'b0100; bb_a[2] = 32'h0000_0005;  bb_b[2] = 32'd3;
        bb_op[3] = 4'b0000; bb_a[3] = 32'h1234_5678;  bb_b[3] = 32'h0F0F_0F0F;
        fork
            begin
                int k, guard;
                k = 0; guard = 0;
                while (k < 4 && guard < 50) begin
                    Operation = bb_op[k]; SrcA = bb_a[k]; SrcB = bb_b[k]; in_valid = 1'b1;
                    if (in_ready) begin
                        acc_cyc[k] = cyc;
                        k++;
                    end
                    @(negedge clk);
                    guard++;
                end
                in_valid = 1'b0;
                check("b2b all accepted", k, 4);
            end
            begin
                repeat (25) begin
                    @(negedge clk);
                    if (out_valid) begin
                        out_cyc.push_back(cyc);
                        out_res.push_back(ALUResult);
                    end
                end
            end
        join
        check("b2b result count", out_res.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < out_res.size()) begin
                check($sformatf("b2b result %0d", i), out_res[i], model(bb_op[i], bb_a[i], bb_b[i]));
                check($sformatf("b2b latency %0d", i), out_cyc[i] - acc_cyc[i],
                      model_lat(bb_op[i], bb_b[i]) + 1);
            end
        end
        if (out_cyc.size() > 2)
            check("b2b AND accepted in SLL done cycle", acc_cyc[3], out_cyc[2]);

        // Reset during an SRL by 20 aborts it without a result.
        @(negedge clk);
        Operation = 4'b0101; SrcA = 32'hFFFF_0000; SrcB = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort ALUResult", ALUResult, 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort Zero", 32'(Zero), 32'd1);
        ovcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) ovcnt++;
        end
        check("abort no late out_valid", ovcnt, 0);
        run_op(4'b0001, 32'hF0, 32'h0F, res, z, lat, low, ok);
        check("post-abort OR done", 32'(ok), 32'd1);
        check("post-abort OR result", res, 32'hFF);

        // Random ops against the model.
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(op, a, b, res, z, lat, low, ok);
            if (!ok) begin
                check($sformatf("rand %0d op %0d done", i, op), 32'(ok), 32'd1);
            end else begin
                check($sformatf("rand %0d op %0d result", i, op), res, model(op, a, b));
                check($sformatf("rand %0d op %0d zero", i, op), 32'(z),
                      (model(op, a, b) == 32'd0) ? 32'd1 : 32'd0);
                check($sformatf("rand %0d op %0d latency", i, op), lat, model_lat(op, b));
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
